// File: rtl/insn_sequencer.sv
// insn_sequencer: fetches one instruction from the IP line, decodes it and
// dispatches it to the data line (+ - ,), the AP line (> <) or host output (.).
// Feeds the data-zero flag back to the IP line and supports run, single-step
// and halt.
// Ports:
//   Clk, Rst_n                 clock, synchronous active-low reset
//   Run, Step, Halted          run level, single-step pulse, halt status
//   IP_Request/Ready/Insn      fetch handshake with the IP line
//   dataIsZeroed               registered data-zero flag to the IP line
//   Data_Request/Dec/Set       data counter request (+, -, load for ',')
//   Data_Ready, Data_Zero      data counter status
//   AP_Request/Dec, AP_Ready   address-pointer request and status
//   In_Valid, In_Ack           host input byte handshake
//   Out_Valid                  pulse when '.' executes
`timescale 1ns/1ps

module insn_sequencer #(
    parameter int unsigned INSN_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Run,
    input  logic                  Step,
    output logic                  Halted,
    output logic                  IP_Request,
    input  logic                  IP_Ready,
    input  logic [INSN_WIDTH-1:0] IP_Insn,
    output logic                  dataIsZeroed,
    output logic                  Data_Request,
    output logic                  Data_Dec,
    output logic                  Data_Set,
    input  logic                  Data_Ready,
    input  logic                  Data_Zero,
    output logic                  AP_Request,
    output logic                  AP_Dec,
    input  logic                  AP_Ready,
    input  logic                  In_Valid,
    output logic                  In_Ack,
    output logic                  Out_Valid
);

    // Host bytes travel straight to the data line; only the width is shared.
    if (DATA_WIDTH == 0) begin : g_no_host_path
    end

    // Codes with dispatch side effects; NOP, '[', ']' and 10-15 fall to default.
    localparam logic [INSN_WIDTH-1:0] OP_HALT  = INSN_WIDTH'(1);
    localparam logic [INSN_WIDTH-1:0] OP_ADD   = INSN_WIDTH'(2);
    localparam logic [INSN_WIDTH-1:0] OP_SUB   = INSN_WIDTH'(3);
    localparam logic [INSN_WIDTH-1:0] OP_RIGHT = INSN_WIDTH'(4);
    localparam logic [INSN_WIDTH-1:0] OP_LEFT  = INSN_WIDTH'(5);
    localparam logic [INSN_WIDTH-1:0] OP_OUT   = INSN_WIDTH'(8);
    localparam logic [INSN_WIDTH-1:0] OP_IN    = INSN_WIDTH'(9);

    typedef enum logic [3:0] {
        S_IDLE,
        S_F_REQ,
        S_F_WAIT,
        S_EXEC,
        S_D_REQ,
        S_D_WAIT,
        S_A_REQ,
        S_A_WAIT,
        S_DONE,
        S_HALT
    } state_t;

    state_t                  state, state_nxt;
    logic [INSN_WIDTH-1:0]   insn, insn_nxt;
    logic                    halted_nxt, ip_req_nxt, zeroed_nxt;
    logic                    data_req_nxt, data_dec_nxt, data_set_nxt;
    logic                    ap_req_nxt, ap_dec_nxt, in_ack_nxt, out_valid_nxt;

    // State and registered outputs.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state        <= S_IDLE;
            insn         <= '0;
            Halted       <= 1'b0;
            IP_Request   <= 1'b0;
            dataIsZeroed <= 1'b0;
            Data_Request <= 1'b0;
            Data_Dec     <= 1'b0;
            Data_Set     <= 1'b0;
            AP_Request   <= 1'b0;
            AP_Dec       <= 1'b0;
            In_Ack       <= 1'b0;
            Out_Valid    <= 1'b0;
        end else begin
            state        <= state_nxt;
            insn         <= insn_nxt;
            Halted       <= halted_nxt;
            IP_Request   <= ip_req_nxt;
            dataIsZeroed <= zeroed_nxt;
            Data_Request <= data_req_nxt;
            Data_Dec     <= data_dec_nxt;
            Data_Set     <= data_set_nxt;
            AP_Request   <= ap_req_nxt;
            AP_Dec       <= ap_dec_nxt;
            In_Ack       <= in_ack_nxt;
            Out_Valid    <= out_valid_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt     = state;
        insn_nxt      = insn;
        halted_nxt    = Halted;
        ip_req_nxt    = IP_Request;
        zeroed_nxt    = dataIsZeroed;
        data_req_nxt  = Data_Request;
        data_dec_nxt  = Data_Dec;
        data_set_nxt  = Data_Set;
        ap_req_nxt    = AP_Request;
        ap_dec_nxt    = AP_Dec;
        in_ack_nxt    = 1'b0;
        out_valid_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                // Step only matters here with Run low; Run=1 already fetches.
                if (Run || Step) begin
                    state_nxt  = S_F_REQ;
                    ip_req_nxt = 1'b1;
                end
            end
            S_F_REQ: begin
                if (!IP_Ready) begin
                    state_nxt = S_F_WAIT;
                end
            end
            S_F_WAIT: begin
                if (IP_Ready) begin
                    insn_nxt   = IP_Insn;
                    ip_req_nxt = 1'b0;
                    state_nxt  = S_EXEC;
                end
            end
            S_EXEC: begin
                case (insn)
                    OP_ADD, OP_SUB: begin
                        data_req_nxt = 1'b1;
                        data_dec_nxt = (insn == OP_SUB);
                        data_set_nxt = 1'b0;
                        state_nxt    = S_D_REQ;
                    end
                    OP_IN: begin
                        // Hold in EXEC until the host has a byte to load.
                        if (In_Valid) begin
                            data_req_nxt = 1'b1;
                            data_dec_nxt = 1'b0;
                            data_set_nxt = 1'b1;
                            state_nxt    = S_D_REQ;
                        end
                    end
                    OP_RIGHT, OP_LEFT: begin
                        ap_req_nxt = 1'b1;
                        ap_dec_nxt = (insn == OP_LEFT);
                        state_nxt  = S_A_REQ;
                    end
                    OP_OUT: begin
                        out_valid_nxt = 1'b1;
                        state_nxt     = S_DONE;
                    end
                    OP_HALT: begin
                        halted_nxt = 1'b1;
                        state_nxt  = S_HALT;
                    end
                    default: begin
                        state_nxt = S_DONE;
                    end
                endcase
            end
            S_D_REQ: begin
                // Request withdrawn as soon as the counter shows busy.
                if (!Data_Ready) begin
                    data_req_nxt = 1'b0;
                    data_dec_nxt = 1'b0;
                    data_set_nxt = 1'b0;
                    state_nxt    = S_D_WAIT;
                end
            end
            S_D_WAIT: begin
                if (Data_Ready) begin
                    in_ack_nxt = (insn == OP_IN);
                    state_nxt  = S_DONE;
                end
            end
            S_A_REQ: begin
                if (!AP_Ready) begin
                    ap_req_nxt = 1'b0;
                    ap_dec_nxt = 1'b0;
                    state_nxt  = S_A_WAIT;
                end
            end
            S_A_WAIT: begin
                if (AP_Ready) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Only point where the branch flag moves, so it is stable during fetch.
                zeroed_nxt = Data_Zero;
                if (Run) begin
                    state_nxt  = S_F_REQ;
                    ip_req_nxt = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_insn_sequencer.sv
// Scoreboard bench for insn_sequencer: behavioural IP/data/AP peers, directed
// instruction streams, a negedge monitor that pops expected dispatch events.
`timescale 1ns/1ps

module tb_insn_sequencer;

    logic       clk;
    logic       rst_n, run, step, halted;
    logic       ip_request, ip_ready;
    logic [3:0] ip_insn;
    logic       dz, data_request, data_dec, data_set, data_ready, data_zero;
    logic       ap_request, ap_dec, ap_ready;
    logic       in_valid, in_ack, out_valid;

    int         n_cmp  = 0;
    int         n_fail = 0;
    int         fetches = 0;
    int         sb[$];
    logic [3:0] ip_q[$];
    logic       zero_q[$];

    insn_sequencer #(.INSN_WIDTH(4), .DATA_WIDTH(8)) dut (
        .Clk(clk), .Rst_n(rst_n), .Run(run), .Step(step), .Halted(halted),
        .IP_Request(ip_request), .IP_Ready(ip_ready), .IP_Insn(ip_insn),
        .dataIsZeroed(dz),
        .Data_Request(data_request), .Data_Dec(data_dec), .Data_Set(data_set),
        .Data_Ready(data_ready), .Data_Zero(data_zero),
        .AP_Request(ap_request), .AP_Dec(ap_dec), .AP_Ready(ap_ready),
        .In_Valid(in_valid), .In_Ack(in_ack), .Out_Valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Event code: kind*4 + dec*2 + set. 1=data req, 2=AP req, 3=out, 4=in ack.
    function automatic int ev(int kind, logic dec, logic set);
        return kind * 4 + (dec ? 2 : 0) + (set ? 1 : 0);
    endfunction

    function automatic int outs();
        return int'({halted, ip_request, dz, data_request, data_dec, data_set,
                     ap_request, ap_dec, in_ack, out_valid});
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic got_event(input int code);
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got %0d, want none", code);
        end else begin
            int want;
            want = sb.pop_front();
            if (code != want) begin
                n_fail++;
                $display("FAIL dispatch_event: got %0d, want %0d", code, want);
            end
        end
    endtask

    // IP line peer: busy for one cycle after a request, then ready with the insn.
    int ip_ph;
    always @(posedge clk) begin
        if (!rst_n) begin
            ip_ready <= 1'b1;
            ip_insn  <= 4'd0;
            ip_ph    <= 0;
        end else begin
            case (ip_ph)
                0: if (ip_request) begin ip_ready <= 1'b0; ip_ph <= 1; end
                1: begin
                    ip_ready <= 1'b1;
                    ip_insn  <= (ip_q.size() != 0) ? ip_q.pop_front() : 4'd0;
                    ip_ph    <= 2;
                end
                default: if (!ip_request) ip_ph <= 0;
            endcase
        end
    end

    // Data counter peer: one busy cycle; zero flag after each op is scripted.
    int d_ph;
    initial data_zero = 1'b0;
    always @(posedge clk) begin
        if (!rst_n) begin
            data_ready <= 1'b1;
            d_ph       <= 0;
        end else if (d_ph == 0) begin
            if (data_request) begin data_ready <= 1'b0; d_ph <= 1; end
        end else begin
            data_ready <= 1'b1;
            if (zero_q.size() != 0) data_zero <= zero_q.pop_front();
            d_ph <= 0;
        end
    end

    // AP counter peer.
    int a_ph;
    always @(posedge clk) begin
        if (!rst_n) begin
            ap_ready <= 1'b1;
            a_ph     <= 0;
        end else if (a_ph == 0) begin
            if (ap_request) begin ap_ready <= 1'b0; a_ph <= 1; end
        end else begin
            ap_ready <= 1'b1;
            a_ph     <= 0;
        end
    end

    // Monitor: dispatch events, fetch count, exclusivity, flag stability.
    logic prev_dr = 1'b0, prev_ar = 1'b0, prev_ir = 1'b0, prev_dz = 1'b0;
    always @(negedge clk) begin
        if (data_request && !prev_dr) got_event(ev(1, data_dec, data_set));
        if (ap_request && !prev_ar)   got_event(ev(2, ap_dec, 1'b0));
        if (out_valid)                got_event(ev(3, 1'b0, 1'b0));
        if (in_ack)                   got_event(ev(4, 1'b0, 1'b0));
        if (ip_request && !prev_ir)   fetches++;
        n_cmp++;
        if ((int'(ip_request) + int'(data_request) + int'(ap_request)) > 1) begin
            n_fail++;
            $display("FAIL request_exclusive: got ip=%0b data=%0b ap=%0b, want at most one",
                     ip_request, data_request, ap_request);
        end
        if (ip_request && prev_ir) begin
            n_cmp++;
            if (dz != prev_dz) begin
                n_fail++;
                $display("FAIL zeroed_stable: got %0b, want %0b", dz, prev_dz);
            end
        end
        prev_dr = data_request;
        prev_ar = ap_request;
        prev_ir = ip_request;
        prev_dz = dz;
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_step();
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic wait_sb(input string name, input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(name, sb.size(), 0);
    endtask

    initial begin
        int f0;
        int k;
        rst_n = 1'b0; run = 1'b0; step = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 0);
        rst_n = 1'b1;

        // Free-run stream + + -, flag ends at 1, Run dropped during last insn.
        f0 = fetches;
        ip_q.push_back(4'd2); ip_q.push_back(4'd2); ip_q.push_back(4'd3);
        zero_q.push_back(1'b0); zero_q.push_back(1'b0); zero_q.push_back(1'b1);
        sb.push_back(ev(1, 1'b0, 1'b0));
        sb.push_back(ev(1, 1'b0, 1'b0));
        sb.push_back(ev(1, 1'b1, 1'b0));
        @(negedge clk);
        run = 1'b1;
        wait_sb("t2_stream", 300);
        run = 1'b0;
        settle(20);
        check("t2_parked_ip_request", int'(ip_request), 0);
        check("t2_zeroed", int'(dz), 1);
        check("t2_fetches", fetches - f0, 3);

        // Single step of '>'.
        f0 = fetches;
        ip_q.push_back(4'd4);
        sb.push_back(ev(2, 1'b0, 1'b0));
        pulse_step();
        wait_sb("t3_ap_step", 100);
        settle(20);
        check("t3_single_fetch", fetches - f0, 1);
        check("t3_idle_ip_request", int'(ip_request), 0);

        // ',' waits for In_Valid, loads with Data_Set, then acks.
        ip_q.push_back(4'd9);
        zero_q.push_back(1'b0);
        sb.push_back(ev(1, 1'b0, 1'b1));
        sb.push_back(ev(4, 1'b0, 1'b0));
        pulse_step();
        settle(10);
        check("t4_no_request_without_byte", int'(data_request), 0);
        check("t4_pending_events", sb.size(), 2);
        in_valid = 1'b1;
        wait_sb("t4_in_load_ack", 100);
        settle(5);
        in_valid = 1'b0;
        settle(10);
        check("t4_zeroed", int'(dz), 0);

        // '.' pulses Out_Valid; code 15 does nothing but fetch.
        ip_q.push_back(4'd8);
        sb.push_back(ev(3, 1'b0, 1'b0));
        pulse_step();
        wait_sb("t6_out_pulse", 100);
        settle(20);
        f0 = fetches;
        ip_q.push_back(4'd15);
        pulse_step();
        settle(20);
        check("t6_nop15_fetch", fetches - f0, 1);
        check("t6_nop15_no_events", sb.size(), 0);

        // '+' with the counter reporting zero updates the flag in DONE.
        ip_q.push_back(4'd2);
        zero_q.push_back(1'b1);
        sb.push_back(ev(1, 1'b0, 1'b0));
        pulse_step();
        wait_sb("t6_add_step", 100);
        settle(20);
        check("t6_zeroed_loaded", int'(dz), 1);

        // Reset while the data request is up aborts everything.
        ip_q.push_back(4'd2);
        sb.push_back(ev(1, 1'b0, 1'b0));
        pulse_step();
        wait_sb("t1_data_request_seen", 100);
        check("t1_request_before_reset", int'(data_request), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t1_reset_outputs", outs(), 0);
        rst_n = 1'b1;
        f0 = fetches;
        settle(10);
        check("t1_idle_after_reset", fetches - f0, 0);

        // HALT is terminal: no fetches, Step ignored, only reset clears.
        ip_q.push_back(4'd1);
        @(negedge clk);
        run = 1'b1;
        k = 0;
        while (!halted && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("t5_halted", int'(halted), 1);
        f0 = fetches;
        settle(20);
        check("t5_no_fetch_running", fetches - f0, 0);
        check("t5_ip_request_low", int'(ip_request), 0);
        run = 1'b0;
        pulse_step();
        settle(10);
        check("t5_step_ignored", fetches - f0, 0);
        check("t5_still_halted", int'(halted), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_reset_clears_halt", outs(), 0);
        rst_n = 1'b1;
        settle(5);

        check("scoreboard_drained", sb.size(), 0);
        check("insn_queue_drained", ip_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
